// File: rtl/snn_spi_pkg.sv
// Shared state encoding and mode constants for the SNN SPI configuration controller.
package snn_spi_pkg;

    localparam int   SNN_SPI_DATA_W_DEFAULT = 16;
    localparam logic SNN_SPI_CPOL           = 1'b0;
    localparam logic SNN_SPI_CPHA           = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT_NEXT = 3'd4,
        ST_DESELECT  = 3'd5
    } snn_spi_state_e;

endpackage

// File: rtl/snn_spi_clkgen.sv
// Half-period tick generator: while enabled, pulses tick on the last cycle of every CLK_DIV-cycle period.
module snn_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ONE    = CW'(1'b1);
    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};

    logic [CW-1:0] cnt_r;

    // Down-counter; held at reload while disabled so the first period after en rises is a full one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= RELOAD;
        end else if (!en) begin
            cnt_r <= RELOAD;
        end else if (cnt_r == ZERO) begin
            cnt_r <= RELOAD;
        end else begin
            cnt_r <= cnt_r - ONE;
        end
    end

    assign tick = en && (cnt_r == ZERO);

endmodule

// File: rtl/snn_spi_controller.sv
// SPI mode-0 controller: streams words out MSB first on COPI and returns the word captured on CIPO.
module snn_spi_controller
    import snn_spi_pkg::*;
#(
    parameter int DATA_W  = SNN_SPI_DATA_W_DEFAULT,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_copi,
    input  logic              spi_cipo
);

    localparam int                BW       = $clog2(DATA_W);
    localparam logic [BW-1:0]     LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0]     BIT_ONE  = BW'(1'b1);
    localparam logic [DATA_W-1:0] WORD_Z   = {DATA_W{1'b0}};

    snn_spi_state_e    state_r, state_s;
    logic [DATA_W-1:0] tx_shift_r, tx_shift_s;
    logic [DATA_W-1:0] rx_shift_r, rx_shift_s;
    logic [DATA_W-1:0] rx_data_s;
    logic [BW-1:0]     bit_cnt_r, bit_cnt_s;
    logic              last_r, last_s;
    logic              sck_s, cs_n_s, tx_ready_s, busy_s, rx_valid_s;
    logic              accept_s, en_s, tick_s;

    // tx_ready is a register, so acceptance never feeds back combinationally into it
    assign accept_s = tx_valid && tx_ready;
    assign en_s     = (state_r == ST_SETUP) || (state_r == ST_SHIFT) ||
                      (state_r == ST_HOLD)  || (state_r == ST_DESELECT);
    assign spi_copi = tx_shift_r[DATA_W-1];

    snn_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .en   (en_s),
        .tick (tick_s)
    );

    // Next-state and datapath updates, advanced only on half-period ticks
    always_comb begin
        state_s    = state_r;
        tx_shift_s = tx_shift_r;
        rx_shift_s = rx_shift_r;
        bit_cnt_s  = bit_cnt_r;
        last_s     = last_r;
        sck_s      = spi_sck;
        rx_valid_s = 1'b0;
        rx_data_s  = rx_data;
        case (state_r)
            ST_IDLE, ST_WAIT_NEXT: begin
                if (accept_s) begin
                    state_s    = (state_r == ST_IDLE) ? ST_SETUP : ST_SHIFT;
                    tx_shift_s = tx_data;
                    last_s     = tx_last;
                    bit_cnt_s  = {BW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETUP: begin
                if (tick_s) begin
                    state_s    = ST_SHIFT;
                    sck_s      = ~SNN_SPI_CPOL;
                    rx_shift_s = {rx_shift_r[DATA_W-2:0], spi_cipo};
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (!tick_s) begin
                    state_s = ST_SHIFT;
                end else if (spi_sck == SNN_SPI_CPOL) begin
                    sck_s      = ~SNN_SPI_CPOL;
                    rx_shift_s = {rx_shift_r[DATA_W-2:0], spi_cipo};
                end else if (bit_cnt_r == LAST_BIT) begin
                    // COPI keeps the last bit through HOLD and WAIT_NEXT
                    sck_s   = SNN_SPI_CPOL;
                    state_s = ST_HOLD;
                end else begin
                    sck_s      = SNN_SPI_CPOL;
                    bit_cnt_s  = bit_cnt_r + BIT_ONE;
                    tx_shift_s = {tx_shift_r[DATA_W-2:0], 1'b0};
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    rx_valid_s = 1'b1;
                    rx_data_s  = rx_shift_r;
                    state_s    = last_r ? ST_DESELECT : ST_WAIT_NEXT;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DESELECT: begin
                if (tick_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DESELECT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        cs_n_s     = (state_s == ST_IDLE) || (state_s == ST_DESELECT);
        tx_ready_s = (state_s == ST_IDLE) || (state_s == ST_WAIT_NEXT);
        busy_s     = (state_s != ST_IDLE);
    end

    // State, datapath and registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tx_shift_r <= WORD_Z;
            rx_shift_r <= WORD_Z;
            bit_cnt_r  <= {BW{1'b0}};
            last_r     <= 1'b0;
            spi_sck    <= SNN_SPI_CPOL;
            spi_cs_n   <= 1'b1;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= WORD_Z;
        end else begin
            state_r    <= state_s;
            tx_shift_r <= tx_shift_s;
            rx_shift_r <= rx_shift_s;
            bit_cnt_r  <= bit_cnt_s;
            last_r     <= last_s;
            spi_sck    <= sck_s;
            spi_cs_n   <= cs_n_s;
            tx_ready   <= tx_ready_s;
            busy       <= busy_s;
            rx_valid   <= rx_valid_s;
            rx_data    <= rx_data_s;
        end
    end

endmodule
